uart_frame_decoder: RTL and testbench
=====================================

Name: uart_frame_decoder

Overview:
- Sits directly downstream of the UART Receiver and consumes its `data_ready` / `data_out` byte stream.
- Hunts for a sync byte, reads a length byte, packs the payload bytes into WORD_BITS-wide words, and checks an XOR checksum byte.
- Delivers words over a valid/ready handshake to the core-side logic and reports per-frame status.
- Frame format on the wire: SYNC, LEN, LEN payload bytes, CHK.

Parameters:
- DBITS, 8, UART byte width; must match Receiver DBITS.
- WORD_BITS, 32, output word width; must be an integer multiple of DBITS.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 100000, inter-byte timeout in clk cycles; used only with FRAME_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- rx_valid  input  1  single-cycle byte strobe; connects to Receiver data_ready.
- rx_data  input  DBITS  received byte; connects to Receiver data_out; sampled when rx_valid=1.
- word_out  output  WORD_BITS  assembled payload word.
- word_last  output  1  word_out is the final word of the frame.
- word_valid  output  1  word_out holds an undelivered word.
- word_ready  input  1  consumer accepts; transfer occurs when word_valid & word_ready.
- frame_done  output  1  one-cycle pulse, frame finished or aborted.
- frame_err  output  2  status, valid only while frame_done=1: 00 ok, 01 checksum mismatch, 10 word overflow, 11 length error or timeout.

Behaviour:
- Reset (reset=0, async): state=IDLE; word_out=0, word_last=0, word_valid=0, frame_done=0, frame_err=00; internal counters, checksum and overflow flag cleared.
- Reset mid-frame aborts the frame with no frame_done pulse.
- BPW = WORD_BITS/DBITS (4 at defaults).
- FSM states, all advancing only on cycles with rx_valid=1:
  - IDLE: rx_data==SYNC_BYTE -> LEN; any other byte is discarded.
  - LEN: byte==0 or byte mod BPW != 0 -> pulse frame_done with frame_err=11, go to IDLE. Otherwise latch length, clear XOR accumulator and overflow flag, go to PAYLOAD.
  - PAYLOAD: shift byte into the assembly register little-endian (first byte -> bits [DBITS-1:0]); XOR it into the accumulator; increment byte counter. Go to CHECK when counter == length.
  - CHECK: byte compared with accumulator. Next cycle frame_done=1 with frame_err = 10 if overflow flag set, else 01 on mismatch, else 00. Go to IDLE.
- Word completion (every BPW-th payload byte):
  - One cycle after that byte's rx_valid, word_out is loaded, word_valid=1, and word_last=1 iff it is the last word of the frame.
  - If word_valid=1 and word_ready=0 in the completing cycle, the new word is dropped and the overflow flag is set; the held word is untouched.
  - If word_valid=1 and word_ready=1 in the completing cycle, the held word transfers and the new word loads; word_valid stays 1.
- word_valid stays high until a handshake with no simultaneous new word; then it clears the next cycle. word_ready is ignored while word_valid=0.
- Words are released before the checksum is known; the consumer must discard the frame on a nonzero frame_err.
- Max payload is 255 bytes; the byte counter is 8 bits with no wrap inside a frame.
- frame_done is never asserted in two consecutive cycles. rx_valid in the frame_done cycle is processed normally (state is already IDLE).

Optional Feature:
- Macro: FRAME_TIMEOUT_EN.
- Defined:
  - A counter runs while state != IDLE, is cleared on every rx_valid, and is cleared on entering IDLE.
  - On reaching TIMEOUT_CYCLES-1: pulse frame_done with frame_err=11, go to IDLE.
  - A partially assembled word is discarded; a word already presented on word_out is still delivered.
- Undefined: no counter logic; the FSM waits indefinitely for the next byte.

Test Plan:
- Bytes A5 04 11 22 33 44 44, word_ready=1 -> one word 0x44332211 with word_last=1; frame_done with frame_err=00 one cycle after the final byte.
- Same frame with CHK=0x45 -> word 0x44332211 still delivered; frame_done with frame_err=01.
- Bytes A5 03 -> frame_done with frame_err=11 immediately, no word output. Following bytes 00 A5 04 01 02 03 04 04 -> word 0x04030201, frame_err=00.
- A5 08 01..08 CHK=08, word_ready held 0 -> first word 0x04030201 held; second word dropped; frame_done with frame_err=10. Raising word_ready later delivers only 0x04030201.
- Leading garbage 00 FF 5A before a valid frame -> ignored; frame decoded normally. reset pulled low after the 2nd payload byte -> all outputs 0, no frame_done. The next full frame decodes correctly.
- FRAME_TIMEOUT_EN defined, TIMEOUT_CYCLES=50: A5 04 11 then silence -> frame_done with frame_err=11 after 50 cycles, state IDLE. Macro undefined -> no frame_done.

Source files
------------

// File: rtl/uart_frame_decoder.sv
// Frame decoder behind a UART receiver: SYNC, LEN, payload packed into words, XOR checksum.
// Optional inter-byte timeout is built when FRAME_TIMEOUT_EN is defined.
module uart_frame_decoder #(
  parameter int                DBITS          = 8,
  parameter int                WORD_BITS      = 32,
  parameter logic [DBITS-1:0]  SYNC_BYTE      = 8'hA5,
  parameter int                TIMEOUT_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_valid,
  input  logic [DBITS-1:0]     rx_data,
  output logic [WORD_BITS-1:0] word_out,
  output logic                 word_last,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic                 frame_done,
  output logic [1:0]           frame_err
);

  localparam int               BPW   = WORD_BITS / DBITS;
  localparam logic [DBITS-1:0] BPW_V = DBITS'(BPW);

  if ((WORD_BITS % DBITS) != 0 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("uart_frame_decoder: WORD_BITS must be a multiple of DBITS, TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHECK} state_t;

  state_t               state_q, state_d;
  logic [DBITS-1:0]     len_q, cnt_q, lane_q, acc_q;
  logic                 ovf_q;
  logic [WORD_BITS-1:0] asm_q, asm_next;
  logic [DBITS-1:0]     cnt_inc;
  logic                 start_frame, take_byte, word_done, done_d, timeout;
  logic [1:0]           err_d;

  assign cnt_inc = cnt_q + DBITS'(1);

  // Little-endian packing: each new byte enters at the top and moves down.
  if (BPW == 1) begin : g_asm_single
    assign asm_next = rx_data;
  end else begin : g_asm_shift
    assign asm_next = {rx_data, asm_q[WORD_BITS-1:DBITS]};
  end

`ifdef FRAME_TIMEOUT_EN
  localparam int            TMO_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_q;

  assign timeout = (state_q != S_IDLE) && !rx_valid && (tmo_q == TMO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_q <= '0;
    end else if (state_q == S_IDLE || rx_valid || state_d == S_IDLE) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + TMO_W'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    err_d       = 2'b00;
    start_frame = 1'b0;
    take_byte   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_valid && rx_data == SYNC_BYTE) state_d = S_LEN;
      end
      S_LEN: begin
        if (rx_valid) begin
          if (rx_data == '0 || (rx_data % BPW_V) != '0) begin
            done_d  = 1'b1;
            err_d   = 2'b11;
            state_d = S_IDLE;
          end else begin
            start_frame = 1'b1;
            state_d     = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (rx_valid) begin
          take_byte = 1'b1;
          if (cnt_inc == len_q) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (rx_valid) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
          if (ovf_q)                err_d = 2'b10;
          else if (rx_data != acc_q) err_d = 2'b01;
          else                       err_d = 2'b00;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (timeout) begin
      done_d  = 1'b1;
      err_d   = 2'b11;
      state_d = S_IDLE;
    end
  end

  assign word_done = take_byte && (lane_q == BPW_V - DBITS'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q      <= '0;
      cnt_q      <= '0;
      lane_q     <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      asm_q      <= '0;
      word_out   <= '0;
      word_last  <= 1'b0;
      word_valid <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 2'b00;
    end else begin
      frame_done <= done_d;
      frame_err  <= done_d ? err_d : 2'b00;
      if (start_frame) begin
        len_q  <= rx_data;
        cnt_q  <= '0;
        lane_q <= '0;
        acc_q  <= '0;
        ovf_q  <= 1'b0;
      end
      if (take_byte) begin
        asm_q  <= asm_next;
        acc_q  <= acc_q ^ rx_data;
        cnt_q  <= cnt_inc;
        lane_q <= word_done ? '0 : lane_q + DBITS'(1);
      end
      // A completed word may only replace the held one when that one leaves this cycle.
      if (word_done) begin
        if (!word_valid || word_ready) begin
          word_out   <= asm_next;
          word_last  <= (cnt_inc == len_q);
          word_valid <= 1'b1;
        end else begin
          ovf_q <= 1'b1;
        end
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Scoreboard bench for uart_frame_decoder: stimulus pushes expected words/status, a monitor pops them.
module tb_uart_frame_decoder;

  logic        clk;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [31:0] word_out;
  logic        word_last;
  logic        word_valid;
  logic        word_ready;
  logic        frame_done;
  logic [1:0]  frame_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [1:0] err;
    int         at;
  } done_t;

  logic [32:0] wq[$];
  done_t       dq[$];

  uart_frame_decoder #(
    .DBITS(8), .WORD_BITS(32), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .word_out(word_out), .word_last(word_last), .word_valid(word_valid),
    .word_ready(word_ready), .frame_done(frame_done), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops an expectation for every word transfer and every frame_done pulse.
  always @(negedge clk) begin
    if (reset) begin
      if (word_valid && word_ready) begin
        if (wq.size() == 0) begin
          chk("unexpected_word", {31'd0, word_last, word_out}, 64'h1_0000_0000_0000);
        end else begin
          logic [32:0] ew;
          ew = wq.pop_front();
          chk("word", word_out, ew[31:0]);
          chk("word_last", word_last, ew[32]);
        end
      end
      if (frame_done) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", {62'd0, frame_err}, 64'hdead);
        end else begin
          done_t ed;
          ed = dq.pop_front();
          chk("frame_err", frame_err, ed.err);
          if (ed.at >= 0) chk("done_cycle", cyc, ed.at);
        end
      end
    end
  end

  // err < 0: this byte ends no frame; otherwise frame_done is due right after it.
  task automatic send_byte(input logic [7:0] b, input int err);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    if (err >= 0) dq.push_back('{err[1:0], cyc + 1});
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame4(input logic [31:0] w, input logic [7:0] c, input int err);
    wq.push_back({1'b1, w});
    send_byte(8'hA5, -1);
    send_byte(8'h04, -1);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], -1);
    send_byte(c, err);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_word_out"}, word_out, 0);
    chk({tag, "_word_last"}, word_last, 0);
    chk({tag, "_word_valid"}, word_valid, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
  endtask

  initial begin
    reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; word_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_outputs_zero("reset");
    @(posedge clk); #1 reset = 1'b1;

    // Basic frame, then same frame with bad checksum.
    send_frame4(32'h44332211, 8'h44, 0);
    send_frame4(32'h44332211, 8'h45, 1);

    // Length not a multiple of 4, then LEN=0, then recovery.
    send_byte(8'hA5, -1);
    send_byte(8'h03, 3);
    send_byte(8'hA5, -1);
    send_byte(8'h00, 3);
    send_byte(8'h00, -1);
    send_frame4(32'h04030201, 8'h04, 0);

    // Two-word frame with consumer ready.
    wq.push_back({1'b0, 32'h04030201});
    wq.push_back({1'b1, 32'h08070605});
    send_byte(8'hA5, -1);
    send_byte(8'h08, -1);
    for (int i = 1; i <= 8; i++) send_byte(8'(i), -1);
    send_byte(8'h08, 0);

    // Consumer stalled: second word is dropped and overflow is reported.
    word_ready = 1'b0;
    wq.push_back({1'b0, 32'h04030201});
    send_byte(8'hA5, -1);
    send_byte(8'h08, -1);
    for (int i = 1; i <= 8; i++) send_byte(8'(i), -1);
    send_byte(8'h08, 2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("held_valid", word_valid, 1);
    chk("held_word", word_out, 32'h04030201);
    @(posedge clk); #1 word_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("drained_valid", word_valid, 0);

    // Leading garbage is ignored.
    send_byte(8'h00, -1);
    send_byte(8'hFF, -1);
    send_byte(8'h5A, -1);
    send_frame4(32'h44332211, 8'h44, 0);

    // Reset mid-frame: no word, no frame_done.
    send_byte(8'hA5, -1);
    send_byte(8'h04, -1);
    send_byte(8'h11, -1);
    send_byte(8'h22, -1);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk_outputs_zero("midreset");
    @(posedge clk); #1 reset = 1'b1;
    send_frame4(32'hDDCCBBAA, 8'h00, 0);

    // Silence after a partial payload.
`ifdef FRAME_TIMEOUT_EN
    dq.push_back('{2'b11, -1});
    send_byte(8'hA5, -1);
    send_byte(8'h04, -1);
    send_byte(8'h11, -1);
    repeat (120) @(posedge clk);
    send_frame4(32'h04030201, 8'h04, 0);
`else
    send_byte(8'hA5, -1);
    send_byte(8'h04, -1);
    send_byte(8'h11, -1);
    repeat (120) @(posedge clk);
    wq.push_back({1'b1, 32'h44332211});
    send_byte(8'h22, -1);
    send_byte(8'h33, -1);
    send_byte(8'h44, -1);
    send_byte(8'h44, 0);
`endif

    for (int i = 0; i < 50 && (wq.size() != 0 || dq.size() != 0); i++) @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("words_left", wq.size(), 0);
    chk("dones_left", dq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
